// File: rtl/reg_exec_if.sv
// Bundle between reg_exec_stage and its neighbours: the issue handshake, the
// register-bank read/write ports and the status flags.
interface reg_exec_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          issue_valid;
    logic          issue_ready;
    logic [2:0]    op;
    logic [AW-1:0] srcA;
    logic [AW-1:0] srcB;
    logic [AW-1:0] dst;
    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    logic [DW-1:0] outA;
    logic [DW-1:0] outB;
    logic          WE;
    logic [AW-1:0] inAddr;
    logic [DW-1:0] inData;
    logic          done;
    logic          zero;
    logic          carry;

    // master: issuing logic plus the register bank
    modport master (
        output issue_valid, op, srcA, srcB, dst, outA, outB,
        input  issue_ready, addrA, addrB, WE, inAddr, inData, done, zero, carry
    );

    // slave: the execute stage
    modport slave (
        input  issue_valid, op, srcA, srcB, dst, outA, outB,
        output issue_ready, addrA, addrB, WE, inAddr, inData, done, zero, carry
    );
endinterface

// File: rtl/reg_exec_stage.sv
// Execute/write-back stage behind the 8x16 register bank, one instruction in flight.
// Macro EXEC_MUL_EN builds the 16-cycle shift-add multiplier for op 111.
//
// state | meaning
// IDLE  | waiting for an instruction, issue_ready high
// READ  | bank read addresses driven, operands captured at the closing edge
// EXEC  | ALU result in one cycle, or 16-cycle multiply
// WB    | WE/done high, result presented on inAddr/inData
module reg_exec_stage #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input logic        clk,
    input logic        rst_n,
    reg_exec_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    state_t        state;
    logic [2:0]    opReg;
    logic [AW-1:0] dstReg;
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;
    logic [DW-1:0] aluRes;
    logic          aluCarry;

    assign bus.issue_ready = (state == IDLE);

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(DW);

    logic [2*DW-1:0] mulAcc;
    logic [2*DW-1:0] mulCand;
    logic [2*DW-1:0] accNext;
    logic [DW-1:0]   mulPlier;
    logic [CW-1:0]   mulCnt;

    // the last partial product is folded in on the edge that leaves EXEC
    assign accNext = mulAcc + (mulPlier[0] ? mulCand : '0);
`endif

    always_comb begin
        aluRes   = '0;
        aluCarry = 1'b0;
        case (opReg)
            OP_ADD: {aluCarry, aluRes} = {1'b0, opA} + {1'b0, opB};
            OP_SUB: begin
                aluRes   = opA - opB;
                aluCarry = (opA < opB);
            end
            OP_AND: aluRes = opA & opB;
            OP_OR:  aluRes = opA | opB;
            OP_XOR: aluRes = opA ^ opB;
            OP_SHL: aluRes = opA << opB[3:0];
            OP_SHR: aluRes = opA >> opB[3:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            opReg      <= '0;
            dstReg     <= '0;
            opA        <= '0;
            opB        <= '0;
            bus.addrA  <= '0;
            bus.addrB  <= '0;
            bus.WE     <= 1'b0;
            bus.done   <= 1'b0;
            bus.inAddr <= '0;
            bus.inData <= '0;
            bus.zero   <= 1'b0;
            bus.carry  <= 1'b0;
`ifdef EXEC_MUL_EN
            mulAcc     <= '0;
            mulCand    <= '0;
            mulPlier   <= '0;
            mulCnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.issue_valid) begin
                        opReg     <= bus.op;
                        dstReg    <= bus.dst;
                        bus.addrA <= bus.srcA;
                        bus.addrB <= bus.srcB;
                        state     <= READ;
                    end
                end
                READ: begin
                    opA      <= bus.outA;
                    opB      <= bus.outB;
`ifdef EXEC_MUL_EN
                    mulAcc   <= '0;
                    mulCand  <= {{DW{1'b0}}, bus.outA};
                    mulPlier <= bus.outB;
                    mulCnt   <= '0;
`endif
                    state    <= EXEC;
                end
                EXEC: begin
                    if (opReg == OP_MUL) begin
`ifdef EXEC_MUL_EN
                        if (mulCnt == CW'(DW - 1)) begin
                            bus.inData <= accNext[DW-1:0];
                            bus.carry  <= |accNext[2*DW-1:DW];
                            bus.zero   <= (accNext[DW-1:0] == '0);
                            bus.inAddr <= dstReg;
                            bus.WE     <= 1'b1;
                            bus.done   <= 1'b1;
                            state      <= WB;
                        end else begin
                            mulAcc   <= accNext;
                            mulCand  <= mulCand << 1;
                            mulPlier <= mulPlier >> 1;
                            mulCnt   <= mulCnt + 1'b1;
                        end
`else
                        // no multiplier: drop the instruction without a write
                        state <= IDLE;
`endif
                    end else begin
                        bus.inData <= aluRes;
                        bus.carry  <= aluCarry;
                        bus.zero   <= (aluRes == '0);
                        bus.inAddr <= dstReg;
                        bus.WE     <= 1'b1;
                        bus.done   <= 1'b1;
                        state      <= WB;
                    end
                end
                WB: begin
                    bus.WE   <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_exec_stage.sv
// Bench for reg_exec_stage: behavioural 8x16 register bank, directed vector
// table for the ALU ops, hand-written sequences for multiply and mid-op reset.
module tb_reg_exec_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_exec_if #(.DW(16), .AW(3)) bus ();

    reg_exec_stage #(.DW(16), .AW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] bank [8];
    logic        pokeEn = 1'b0;
    logic [2:0]  pokeAddr = '0;
    logic [15:0] pokeData = '0;

    always @(posedge clk) begin
        if (pokeEn) bank[pokeAddr] <= pokeData;
        if (bus.WE) bank[bus.inAddr] <= bus.inData;
    end

    assign bus.outA = bank[bus.addrA];
    assign bus.outB = bank[bus.addrB];

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [2:0]  d;
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] expD;
        logic        expC;
        logic        expZ;
        int          expLat;
    } vec_t;

    vec_t vecs [16];
    int   nVec = 0;
    int   nChecks = 0;
    int   nFail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        pokeEn   = 1'b1;
        pokeAddr = addr;
        pokeData = data;
        @(negedge clk);
        pokeEn = 1'b0;
    endtask

    // offer one instruction at a negedge; returns just after the accept edge
    task automatic issue(input string name, input logic [2:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic [2:0] d);
        @(negedge clk);
        chk({name, " ready before issue"}, 32'(bus.issue_ready), 32'(1));
        bus.issue_valid = 1'b1;
        bus.op   = op;
        bus.srcA = a;
        bus.srcB = b;
        bus.dst  = d;
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        bus.op   = 3'($urandom);
        bus.srcA = 3'($urandom);
        bus.srcB = 3'($urandom);
        bus.dst  = 3'($urandom);
    endtask

    task automatic runVec(input vec_t v, input string name);
        int lat;
        bit seen;
        poke(v.a, v.va);
        if (v.b != v.a) poke(v.b, v.vb);
        issue(name, v.op, v.a, v.b, v.d);
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 25 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk({name, " addrA"}, 32'(bus.addrA), 32'(v.a));
                chk({name, " addrB"}, 32'(bus.addrB), 32'(v.b));
            end
            if (bus.WE) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        chk({name, " WE cycle"}, 32'(lat), 32'(v.expLat));
        chk({name, " inAddr"}, 32'(bus.inAddr), 32'(v.d));
        chk({name, " inData"}, 32'(bus.inData), 32'(v.expD));
        chk({name, " done"}, 32'(bus.done), 32'(1));
        chk({name, " carry"}, 32'(bus.carry), 32'(v.expC));
        chk({name, " zero"}, 32'(bus.zero), 32'(v.expZ));
        if (v.d == v.a)
            chk({name, " dst old before WB edge"}, 32'(bank[v.d]), 32'(v.va));
        @(negedge clk);
        chk({name, " WE dropped"}, 32'(bus.WE), 32'(0));
        chk({name, " done dropped"}, 32'(bus.done), 32'(0));
        chk({name, " ready after WB"}, 32'(bus.issue_ready), 32'(1));
        chk({name, " bank written"}, 32'(bank[v.d]), 32'(v.expD));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit anyWe;
        vecs[0]  = '{3'b000, 3'd2, 3'd4, 3'd1, 16'h35A1, 16'h1234, 16'h47D5, 1'b0, 1'b0, 3};
        vecs[1]  = '{3'b001, 3'd1, 3'd2, 3'd5, 16'h1234, 16'h35A1, 16'hDC93, 1'b1, 1'b0, 3};
        vecs[2]  = '{3'b000, 3'd3, 3'd3, 3'd3, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 3};
        vecs[3]  = '{3'b101, 3'd6, 3'd7, 3'd0, 16'h8001, 16'h0011, 16'h0002, 1'b0, 1'b0, 3};
        vecs[4]  = '{3'b110, 3'd6, 3'd7, 3'd0, 16'h8001, 16'h0011, 16'h4000, 1'b0, 1'b0, 3};
        vecs[5]  = '{3'b010, 3'd1, 3'd2, 3'd4, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 3};
        vecs[6]  = '{3'b011, 3'd1, 3'd2, 3'd4, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0, 3};
        vecs[7]  = '{3'b100, 3'd1, 3'd2, 3'd6, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 3};
        vecs[8]  = '{3'b000, 3'd1, 3'd2, 3'd2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 3};
        vecs[9]  = '{3'b001, 3'd3, 3'd4, 3'd5, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 3};
        vecs[10] = '{3'b101, 3'd5, 3'd6, 3'd7, 16'h0003, 16'h000F, 16'h8000, 1'b0, 1'b0, 3};
        vecs[11] = '{3'b110, 3'd0, 3'd1, 3'd2, 16'hABCD, 16'h0010, 16'hABCD, 1'b0, 1'b0, 3};
        nVec = 12;
`ifdef EXEC_MUL_EN
        vecs[12] = '{3'b111, 3'd1, 3'd2, 3'd3, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 18};
        vecs[13] = '{3'b111, 3'd4, 3'd5, 3'd6, 16'h1234, 16'h0010, 16'h2340, 1'b1, 1'b0, 18};
        nVec = 14;
`endif

        bus.issue_valid = 1'b0;
        bus.op   = '0;
        bus.srcA = '0;
        bus.srcB = '0;
        bus.dst  = '0;

        repeat (2) @(negedge clk);
        chk("reset WE", 32'(bus.WE), 32'(0));
        chk("reset done", 32'(bus.done), 32'(0));
        chk("reset inData", 32'(bus.inData), 32'(0));
        chk("reset addrA", 32'(bus.addrA), 32'(0));
        chk("reset zero/carry", 32'({bus.zero, bus.carry}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", 32'(bus.issue_ready), 32'(1));

        for (int i = 0; i < nVec; i++)
            runVec(vecs[i], $sformatf("vec%0d", i));

`ifndef EXEC_MUL_EN
        // op 111 without multiplier: no write, flags kept from vec8 (carry=1, zero=1)
        runVec(vecs[8], "flags setup");
        poke(3'd7, 16'h5A5A);
        poke(3'd1, 16'h0012);
        poke(3'd2, 16'h0034);
        issue("nomul", 3'b111, 3'd1, 3'd2, 3'd7);
        anyWe = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.WE || bus.done) anyWe = 1'b1;
            if (c == 2) chk("nomul busy in EXEC", 32'(bus.issue_ready), 32'(0));
            if (c == 3) chk("nomul back in IDLE", 32'(bus.issue_ready), 32'(1));
        end
        chk("nomul no WE/done", 32'(anyWe), 32'(0));
        chk("nomul bank untouched", 32'(bank[7]), 32'(16'h5A5A));
        chk("nomul flags kept", 32'({bus.zero, bus.carry}), 32'(2'b11));
`endif

        // reset while an instruction sits in EXEC
        poke(3'd7, 16'h5A5A);
        poke(3'd1, 16'h1234);
        poke(3'd2, 16'h0010);
`ifdef EXEC_MUL_EN
        issue("rstmid", 3'b111, 3'd1, 3'd2, 3'd7);
        k = 7;
`else
        issue("rstmid", 3'b000, 3'd1, 3'd2, 3'd7);
        k = 2;
`endif
        repeat (k) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid WE", 32'(bus.WE), 32'(0));
        chk("rstmid done", 32'(bus.done), 32'(0));
        chk("rstmid addrA/addrB", 32'({bus.addrA, bus.addrB}), 32'(0));
        chk("rstmid inAddr/inData", 32'({bus.inAddr, bus.inData}), 32'(0));
        chk("rstmid flags", 32'({bus.zero, bus.carry}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        anyWe = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.WE) anyWe = 1'b1;
        end
        chk("rstmid no write", 32'(anyWe), 32'(0));
        chk("rstmid bank untouched", 32'(bank[7]), 32'(16'h5A5A));
        chk("rstmid ready", 32'(bus.issue_ready), 32'(1));
        runVec(vecs[0], "post-reset add");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/reg_exec_stage.md
Name: reg_exec_stage

Overview:
- Execute/write-back stage that sits directly downstream of the 8x16 register bank.
- Accepts one 3-operand instruction per handshake, drives the bank read addresses, and latches outA/outB.
- Computes a 16-bit ALU result, single-cycle or 16-cycle multiply, then writes it back through the bank write port (WE/inAddr/inData).
- Sequencing is a 4-state FSM; one instruction is in flight at a time.

Parameters:
- DW, 16: data width; matches register bank word width.
- AW, 3: register address width (8 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  stage can accept; high only in IDLE.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- srcA  in  AW  first source register.
- srcB  in  AW  second source register.
- dst  in  AW  destination register.
- addrA  out  AW  to bank addrA.
- addrB  out  AW  to bank addrB.
- outA  in  DW  from bank, combinational read data A.
- outB  in  DW  from bank, combinational read data B.
- WE  out  1  to bank write enable.
- inAddr  out  AW  to bank write address.
- inData  out  DW  to bank write data.
- done  out  1  one-cycle pulse coincident with the WE cycle.
- zero  out  1  registered; result==0 of last completed op.
- carry  out  1  registered; carry/borrow/overflow of last completed op.

Behaviour:
- Reset (async, immediate): state=IDLE; WE=0, done=0, addrA=addrB=inAddr=0, inData=0, zero=0, carry=0. issue_ready=1 once rst_n deasserts.
- IDLE: issue_ready=1. On issue_valid&&issue_ready at an edge, latch op/srcA/srcB/dst and go to READ. issue_valid is ignored outside IDLE; the fields need not be held after acceptance.
- READ (1 cycle): addrA=srcA, addrB=srcB registered outputs valid for the whole cycle. At the closing edge, capture opA=outA, opB=outB and go to EXEC.
- EXEC, non-MUL ops (1 cycle): register res and flags, then go to WB.
  - ADD: 17-bit sum; carry=bit16.
  - SUB: opA-opB mod 2^16; carry=1 iff opA<opB unsigned.
  - AND/OR/XOR: carry=0.
  - SHL/SHR: logical shift by opB[3:0], zero fill; carry=0.
- EXEC, MUL (16 cycles): shift-add over opB bits LSB-first into a 32-bit accumulator; counter 0..15. res=product[15:0]; carry=|product[31:16].
- zero=(res==0) for all ops. Flags update only at the EXEC->WB transition.
- WB (1 cycle): WE=1, inAddr=dst, inData=res, done=1. The bank writes at the closing edge. Return to IDLE; WE/done drop the next cycle.
- Latency: accept edge to WE cycle is 3 cycles for non-MUL ops and 18 cycles for MUL. Non-MUL throughput is 1 instruction per 4 cycles.
- dst equal to srcA or srcB is legal: operands are captured in READ, before the write.
- WE is never asserted outside WB. inAddr/inData hold their last value when WE=0.
- Reset mid-operation: the in-flight instruction is discarded with no write; WE=0 immediately.

Optional Feature:
- Macro EXEC_MUL_EN.
- Defined: op 111 is MUL as described above.
- Undefined: multiplier and counter are not built. op 111 passes READ and EXEC in 1 cycle each, then goes to IDLE with no WB: WE=0, done=0, flags unchanged.

Test Plan:
- ADD: bank r2=0x35A1, r4=0x1234; issue op=000 srcA=2 srcB=4 dst=1 -> WE 3 cycles after accept; inAddr=1, inData=0x47D5, carry=0, zero=0, done pulse 1 cycle.
- SUB with borrow: r1=0x1234, r2=0x35A1; op=001 A=1 B=2 dst=5 -> inData=0xDC93, carry=1.
- Self-operand: r3=0x8000; op=000 A=3 B=3 dst=3 -> inData=0x0000, zero=1, carry=1; the new r3 is visible only after the WB edge.
- Shift: r6=0x8001, r7=0x0011; op=101 A=6 B=7 dst=0 -> inData=0x0002 (shift by 1). op=110 same operands -> 0x4000.
- MUL (EXEC_MUL_EN): 0x0012*0x0034 -> 0x03A8, carry=0, WE 18 cycles after accept. 0x1234*0x0010 -> 0x2340, carry=1. With the macro undefined: op=111 -> no WE, back in IDLE 2 cycles after accept.
- Reset mid-MUL: drop rst_n 5 cycles into EXEC -> WE=0, outputs at reset values immediately, no bank write. issue_ready=1 after release; the next ADD completes normally.
